// File: rtl/delay_sched_pkg.sv
// ============================================================================
//  Module      : delay_sched_pkg
//  Description : Shared constants for the delay scheduler: mode encodings,
//                glitch counter width and default delay configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package delay_sched_pkg;

    // Mode encodings as seen on the mode input and held in the config register
    localparam logic MODE_TRANSPORT = 1'b0;
    localparam logic MODE_INERTIAL  = 1'b1;

    // Width of the rejected-pulse counter
    localparam int GLITCH_W = 8;

    // Default delay configuration
    localparam int DEF_MAX_DLY = 15;
    localparam int DEF_DLY_W   = 4;

endpackage : delay_sched_pkg

`default_nettype wire

// File: rtl/delay_sched_if.sv
// ============================================================================
//  Module      : delay_sched_if
//  Description : Signal bundle between a stimulus source (master) and the
//                delay scheduler (slave).
//  Revision    : 1.0 - initial release
//  Signals     : a, cfg_we, dly[DLY_W], mode   master -> slave
//                y, busy                       slave  -> master
//                glitch_cnt[8]                 slave  -> master, only when
//                                              DELAY_GLITCH_CNT_EN is defined
// ============================================================================
`default_nettype none

interface delay_sched_if
    import delay_sched_pkg::*;
#(
    parameter int DLY_W = DEF_DLY_W
) ();

    logic             a;
    logic             cfg_we;
    logic [DLY_W-1:0] dly;
    logic             mode;
    logic             y;
    logic             busy;
`ifdef DELAY_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_cnt;
`endif

    modport master (
        output a, cfg_we, dly, mode,
`ifdef DELAY_GLITCH_CNT_EN
        input  glitch_cnt,
`endif
        input  y, busy
    );

    modport slave (
        input  a, cfg_we, dly, mode,
`ifdef DELAY_GLITCH_CNT_EN
        output glitch_cnt,
`endif
        output y, busy
    );

endinterface : delay_sched_if

`default_nettype wire

// File: rtl/delay_shreg.sv
// ============================================================================
//  Module      : delay_shreg
//  Description : MAX_DLY-deep history shift register of the input samples
//                with a selectable tap. tap==0 selects the live input, so
//                the registered output stage downstream gives a one-cycle
//                path; tap==k selects the sample taken k edges earlier.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst       clock, synchronous active-high reset
//                flush          load every stage with flush_val
//                flush_val      value loaded on flush
//                d              new sample shifted in each edge
//                tap[DLY_W]     tap select 0..MAX_DLY
//                q              selected tap (combinational)
//                taps[MAX_DLY:1] full history, taps[i] = sample i edges old
// ============================================================================
`default_nettype none

module delay_shreg #(
    parameter int MAX_DLY = 15,
    parameter int DLY_W   = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               flush,
    input  wire logic               flush_val,
    input  wire logic               d,
    input  wire logic [DLY_W-1:0]   tap,
    output logic                    q,
    output logic [MAX_DLY:1]        taps
);

    logic [MAX_DLY:1] hist_q;
    logic [MAX_DLY:1] hist_d;

    always_comb begin
        if (flush) begin
            hist_d = {MAX_DLY{flush_val}};
        end else begin
            hist_d[1] = d;
            for (int i = 2; i <= MAX_DLY; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    always_comb begin
        q = d;
        for (int i = 1; i <= MAX_DLY; i++) begin
            if (tap == DLY_W'(i)) begin
                q = hist_q[i];
            end
        end
    end

    assign taps = hist_q;

endmodule : delay_shreg

`default_nettype wire

// File: rtl/delay_sched.sv
// ============================================================================
//  Module      : delay_sched
//  Description : Reproduces transitions of a single-bit input after a
//                programmable number of cycles, in transport mode (every
//                pulse kept) or inertial mode (pulses shorter than the delay
//                are dropped).
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst       clock, synchronous active-high reset
//                bus (slave)    a, cfg_we, dly, mode in; y, busy out;
//                               glitch_cnt out when DELAY_GLITCH_CNT_EN
//  Option      : DELAY_GLITCH_CNT_EN adds an 8-bit saturating counter of
//                pulses rejected in inertial mode.
// ============================================================================
`default_nettype none

module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int MAX_DLY = DEF_MAX_DLY,
    parameter int DLY_W   = DEF_DLY_W
) (
    input  wire logic      clk,
    input  wire logic      rst,
    delay_sched_if.slave   bus
);

    logic             y_q,        y_d;
    logic [DLY_W-1:0] cnt_q,      cnt_d;
    logic [DLY_W-1:0] cfg_dly_q,  cfg_dly_d;
    logic             cfg_mode_q, cfg_mode_d;

    logic             tap_val;
    logic [MAX_DLY:1] taps;
    logic [DLY_W-1:0] dly_clamped;
    logic             busy;
`ifdef DELAY_GLITCH_CNT_EN
    logic                reject;
    logic [GLITCH_W-1:0] glitch_q;
`endif

    // The history always runs, in both modes, so switching mode needs no fill.
    delay_shreg #(
        .MAX_DLY (MAX_DLY),
        .DLY_W   (DLY_W)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.cfg_we),
        .flush_val (y_q),
        .d         (bus.a),
        .tap       (cfg_dly_q),
        .q         (tap_val),
        .taps      (taps)
    );

    assign dly_clamped = (int'(bus.dly) > MAX_DLY) ? DLY_W'(MAX_DLY) : bus.dly;

    always_comb begin
        y_d        = y_q;
        cnt_d      = cnt_q;
        cfg_dly_d  = cfg_dly_q;
        cfg_mode_d = cfg_mode_q;
`ifdef DELAY_GLITCH_CNT_EN
        reject     = 1'b0;
`endif
        if (bus.cfg_we) begin
            // Config write flushes in-flight state; y holds, a is discarded.
            cfg_dly_d  = dly_clamped;
            cfg_mode_d = bus.mode;
            cnt_d      = '0;
        end else if (cfg_mode_q == MODE_TRANSPORT) begin
            y_d   = tap_val;
            cnt_d = '0;
        end else if (bus.a == y_q) begin
            // Input fell back before the run completed: pulse rejected.
`ifdef DELAY_GLITCH_CNT_EN
            reject = (cnt_q != '0);
`endif
            cnt_d  = '0;
        end else if (cnt_q == cfg_dly_q) begin
            y_d   = bus.a;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DLY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q        <= 1'b0;
            cnt_q      <= '0;
            cfg_dly_q  <= '0;
            cfg_mode_q <= MODE_TRANSPORT;
        end else begin
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            cfg_dly_q  <= cfg_dly_d;
            cfg_mode_q <= cfg_mode_d;
        end
    end

    // Derived from registered state only, never from the live input.
    always_comb begin
        busy = 1'b0;
        if (cfg_mode_q == MODE_INERTIAL) begin
            busy = (cnt_q != '0);
        end else begin
            for (int i = 1; i <= MAX_DLY; i++) begin
                if ((DLY_W'(i) <= cfg_dly_q) && (taps[i] != y_q)) begin
                    busy = 1'b1;
                end
            end
        end
    end

`ifdef DELAY_GLITCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (reject && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign bus.glitch_cnt = glitch_q;
`endif

    assign bus.y    = y_q;
    assign bus.busy = busy;

endmodule : delay_sched

`default_nettype wire
